color_filter_param: RTL and testbench
=====================================

// Module: color_filter_param
// PURPOSE
//  Parametrised, pipelined colour-threshold filter in the camera capture path, between raw RGB and downstream img_proc.
//  Passes pixels where the selected channel is above a primary threshold and both other channels are below a secondary threshold; all other pixels output zero.
//  Thresholds and channel are runtime-programmable and double-buffered so they only change at frame boundaries.
//  Publishes a per-frame match count for the tracking logic.
// PARAMETERS
//  PIX_W      12      colour channel width (bits)
//  COORD_W    11      X/Y coordinate width
//  CNT_W      20      match counter width (saturating)
//  DEF_PRI_TH 'h7FF   reset value of primary threshold (PIX_W bits)
//  DEF_OTH_TH 'h3FF   reset value of secondary threshold (PIX_W bits)
// PORTS
//  iCLK       in   1        clock
//  iRST       in   1        synchronous reset, active-high
//  iX_Cont    in   COORD_W  pixel X
//  iY_Cont    in   COORD_W  pixel Y
//  iRed/iGreen/iBlue in PIX_W  input pixel
//  iDVAL      in   1        input pixel valid
//  iSOF       in   1        start-of-frame pulse; coincides with first pixel of frame (or precedes it)
//  iCFG_WE    in   1        config write strobe
//  iCFG_ADDR  in   2        0=PRI_TH 1=OTH_TH 2=CHAN_SEL(1:0) 3=reserved (write ignored)
//  iCFG_DATA  in   PIX_W    config write data
//  oRed/oGreen/oBlue out PIX_W  filtered pixel
//  oDVAL      out  1        output valid
//  oX/oY      out  COORD_W  coordinates aligned with output pixel
//  oMATCH     out  1        current output pixel passed filter
//  oCOUNT     out  CNT_W    match count of last completed frame
//  oCOUNT_VLD out  1        one-cycle pulse when oCOUNT updates
// BEHAVIOUR
//  Reset: all outputs 0; shadow and active regs = DEF_PRI_TH, DEF_OTH_TH, CHAN_SEL=0 (red); counter 0.
//  Pipeline: 2 cycles, iDVAL at cycle N -> oDVAL at N+2. S1 registers pixel/coords/valid and compare flags; S2 registers muxed output.
//  No backpressure; a bubble (iDVAL=0) propagates as oDVAL=0 and leaves the output pixel registers holding their previous value.
//  Compare: selected channel > PRI_TH (strict); each other channel < OTH_TH (strict); unsigned, PIX_W bits.
//  CHAN_SEL: 0=R 1=G 2=B 3=bypass (every valid pixel passes unmodified, oMATCH=1).
//  Config: writes land in shadow regs the same cycle; shadow copied to active on iSOF. A write in the same cycle as iSOF is NOT applied to the current frame (shadow copy uses the pre-write value).
//  Counter: +1 per valid matching pixel; saturates at all-ones, no wrap.
//  On iSOF: oCOUNT <= counter (including the S2 pixel matching in the same cycle), oCOUNT_VLD=1 for one cycle, counter restarts (0, or 1 if the S2 pixel matches). First iSOF after reset publishes 0.
//  iSOF together with iDVAL: that pixel belongs to the new frame and uses the new active config.
//  Reset mid-frame: pipeline flushed, partial count discarded, no oCOUNT_VLD.
// CONFIGURATION
//  COLOR_FILTER_CENTROID_EN defined: adds oSUM_X/oSUM_Y (COORD_W+CNT_W bits): sums of X/Y over matching pixels, latched and published with oCOUNT/oCOUNT_VLD.
//   They saturate independently of the counter. Cleared by reset.
//  Not defined: ports absent, no accumulators.
// STRUCTURE
//  Package color_filter_pkg: chan_sel_e enum (CH_RED, CH_GREEN, CH_BLUE, CH_BYPASS); CFG_ADDR_* localparams; cfg_t struct {pri_th, oth_th, chan}.
//  Sub-module frame_stat_accum: saturating counter plus optional X/Y sums, frame latch on iSOF.
// TESTING
//  Reset defaults, R=0x800 G=0x3FE B=0x000 -> passes at +2 cycles, oMATCH=1; R=0x7FF -> output 0.
//  Write CHAN_SEL=1 mid-frame, G=0xFFF R=B=0 -> still 0 until next iSOF, then passes.
//  Write CHAN_SEL=3 then iSOF -> every pixel passes unmodified, oMATCH=1.
//  Frame of 100 pixels with 37 matches, then iSOF -> oCOUNT=37, oCOUNT_VLD one cycle.
//  CNT_W=4, 20 matches -> oCOUNT=15.
//  Reset asserted mid-frame, then iSOF -> oCOUNT=0; with CENTROID_EN, 3 matches at X=10,20,30 -> oSUM_X=60.

Source files
------------

// File: rtl/color_filter_pkg.sv
// Shared types for the colour-threshold filter: channel select, config register map, config payload.
// Used by color_filter_param (optional centroid sums under COLOR_FILTER_CENTROID_EN).
package color_filter_pkg;

    // Thresholds are stored at this width; channel widths up to this value are supported.
    localparam int unsigned TH_W_MAX   = 16;
    localparam int unsigned CFG_ADDR_W = 2;

    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_PRI_TH = 2'd0;
    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_OTH_TH = 2'd1;
    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_CHAN   = 2'd2;
    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        CH_RED    = 2'd0,
        CH_GREEN  = 2'd1,
        CH_BLUE   = 2'd2,
        CH_BYPASS = 2'd3
    } chan_sel_e;

    typedef struct packed {
        logic [TH_W_MAX-1:0] pri_th;
        logic [TH_W_MAX-1:0] oth_th;
        chan_sel_e           chan;
    } cfg_t;

    // Selected channel strictly above pri_th, both others strictly below oth_th.
    function automatic logic pix_match(
        input logic [TH_W_MAX-1:0] r,
        input logic [TH_W_MAX-1:0] g,
        input logic [TH_W_MAX-1:0] b,
        input cfg_t                cfg
    );
        logic res;
        res = 1'b0;
        case (cfg.chan)
            CH_RED:    res = (r > cfg.pri_th) && (g < cfg.oth_th) && (b < cfg.oth_th);
            CH_GREEN:  res = (g > cfg.pri_th) && (r < cfg.oth_th) && (b < cfg.oth_th);
            CH_BLUE:   res = (b > cfg.pri_th) && (r < cfg.oth_th) && (g < cfg.oth_th);
            CH_BYPASS: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/frame_stat_accum.sv
// Per-frame saturating match counter, latched and published on start-of-frame.
// COLOR_FILTER_CENTROID_EN adds saturating X/Y coordinate sums published alongside the count.
module frame_stat_accum #(
    parameter int unsigned CNT_W = 20
`ifdef COLOR_FILTER_CENTROID_EN
    ,
    parameter int unsigned COORD_W = 11
`endif
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iSOF,
    input  logic                     iINC,
`ifdef COLOR_FILTER_CENTROID_EN
    input  logic [COORD_W-1:0]       iX,
    input  logic [COORD_W-1:0]       iY,
    output logic [COORD_W+CNT_W-1:0] oSUM_X,
    output logic [COORD_W+CNT_W-1:0] oSUM_Y,
`endif
    output logic [CNT_W-1:0]         oCOUNT,
    output logic                     oCOUNT_VLD
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_vld_q, count_vld_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (iINC && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    // Publishing includes this cycle's matching pixel; the new frame then restarts from it.
    always_comb begin
        cnt_d       = cnt_inc;
        count_d     = count_q;
        count_vld_d = 1'b0;
        if (iSOF) begin
            count_d     = cnt_inc;
            count_vld_d = 1'b1;
            cnt_d       = CNT_W'(iINC);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q       <= '0;
            count_q     <= '0;
            count_vld_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            count_vld_q <= count_vld_d;
        end
    end

    assign oCOUNT     = count_q;
    assign oCOUNT_VLD = count_vld_q;

`ifdef COLOR_FILTER_CENTROID_EN
    localparam int unsigned SUM_W  = COORD_W + CNT_W;
    localparam int unsigned SUM_W1 = SUM_W + 1;

    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [SUM_W-1:0] pub_x_q, pub_x_d, pub_y_q, pub_y_d;
    logic [SUM_W-1:0] sum_x_inc, sum_y_inc;

    function automatic logic [SUM_W-1:0] sat_add(
        input logic [SUM_W-1:0]   acc,
        input logic [COORD_W-1:0] v
    );
        logic [SUM_W:0] s;
        s = {1'b0, acc} + SUM_W1'(v);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    assign sum_x_inc = iINC ? sat_add(sum_x_q, iX) : sum_x_q;
    assign sum_y_inc = iINC ? sat_add(sum_y_q, iY) : sum_y_q;

    always_comb begin
        sum_x_d = sum_x_inc;
        sum_y_d = sum_y_inc;
        pub_x_d = pub_x_q;
        pub_y_d = pub_y_q;
        if (iSOF) begin
            pub_x_d = sum_x_inc;
            pub_y_d = sum_y_inc;
            sum_x_d = iINC ? SUM_W'(iX) : '0;
            sum_y_d = iINC ? SUM_W'(iY) : '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            pub_x_q <= '0;
            pub_y_q <= '0;
        end else begin
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            pub_x_q <= pub_x_d;
            pub_y_q <= pub_y_d;
        end
    end

    assign oSUM_X = pub_x_q;
    assign oSUM_Y = pub_y_q;
`endif

endmodule

// File: rtl/color_filter_param.sv
// Two-stage colour-threshold filter with frame-synchronous double-buffered config and per-frame match count.
// COLOR_FILTER_CENTROID_EN adds oSUM_X/oSUM_Y coordinate sums of matching pixels.
module color_filter_param
    import color_filter_pkg::*;
#(
    parameter int unsigned PIX_W      = 12,
    parameter int unsigned COORD_W    = 11,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned DEF_PRI_TH = 'h7FF,
    parameter int unsigned DEF_OTH_TH = 'h3FF
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [COORD_W-1:0]       iX_Cont,
    input  logic [COORD_W-1:0]       iY_Cont,
    input  logic [PIX_W-1:0]         iRed,
    input  logic [PIX_W-1:0]         iGreen,
    input  logic [PIX_W-1:0]         iBlue,
    input  logic                     iDVAL,
    input  logic                     iSOF,
    input  logic                     iCFG_WE,
    input  logic [CFG_ADDR_W-1:0]    iCFG_ADDR,
    input  logic [PIX_W-1:0]         iCFG_DATA,
    output logic [PIX_W-1:0]         oRed,
    output logic [PIX_W-1:0]         oGreen,
    output logic [PIX_W-1:0]         oBlue,
    output logic                     oDVAL,
    output logic [COORD_W-1:0]       oX,
    output logic [COORD_W-1:0]       oY,
    output logic                     oMATCH,
    output logic [CNT_W-1:0]         oCOUNT,
`ifdef COLOR_FILTER_CENTROID_EN
    output logic [COORD_W+CNT_W-1:0] oSUM_X,
    output logic [COORD_W+CNT_W-1:0] oSUM_Y,
`endif
    output logic                     oCOUNT_VLD
);

    localparam cfg_t CFG_DEF = '{
        pri_th: TH_W_MAX'(PIX_W'(DEF_PRI_TH)),
        oth_th: TH_W_MAX'(PIX_W'(DEF_OTH_TH)),
        chan:   CH_RED
    };

    cfg_t shadow_q, shadow_d;
    cfg_t active_q, active_d;

    logic               s1_vld_q, s1_vld_d;
    logic               s1_match_q, s1_match_d;
    logic [PIX_W-1:0]   s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    logic [COORD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;

    logic               s2_vld_q, s2_vld_d;
    logic               s2_match_q, s2_match_d;
    logic [PIX_W-1:0]   s2_r_q, s2_r_d, s2_g_q, s2_g_d, s2_b_q, s2_b_d;
    logic [COORD_W-1:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;

    logic               s2_inc;

    // Shadow takes writes immediately; active takes the pre-write shadow on iSOF.
    always_comb begin
        shadow_d = shadow_q;
        active_d = iSOF ? shadow_q : active_q;
        if (iCFG_WE) begin
            case (iCFG_ADDR)
                CFG_ADDR_PRI_TH: shadow_d.pri_th = TH_W_MAX'(iCFG_DATA);
                CFG_ADDR_OTH_TH: shadow_d.oth_th = TH_W_MAX'(iCFG_DATA);
                CFG_ADDR_CHAN:   shadow_d.chan   = chan_sel_e'(iCFG_DATA[1:0]);
                CFG_ADDR_RSVD:   shadow_d        = shadow_q;
            endcase
        end
    end

    // S1 compares against active_d so a pixel arriving with iSOF already sees the new frame's config.
    always_comb begin
        s1_vld_d   = iDVAL;
        s1_match_d = iDVAL && pix_match(TH_W_MAX'(iRed), TH_W_MAX'(iGreen), TH_W_MAX'(iBlue), active_d);
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        if (iDVAL) begin
            s1_r_d = iRed;
            s1_g_d = iGreen;
            s1_b_d = iBlue;
            s1_x_d = iX_Cont;
            s1_y_d = iY_Cont;
        end
    end

    // S2 zeroes non-matching pixels; bubbles leave pixel and coordinate registers untouched.
    always_comb begin
        s2_vld_d   = s1_vld_q;
        s2_match_d = s1_vld_q && s1_match_q;
        s2_r_d     = s2_r_q;
        s2_g_d     = s2_g_q;
        s2_b_d     = s2_b_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        if (s1_vld_q) begin
            s2_r_d = s1_match_q ? s1_r_q : '0;
            s2_g_d = s1_match_q ? s1_g_q : '0;
            s2_b_d = s1_match_q ? s1_b_q : '0;
            s2_x_d = s1_x_q;
            s2_y_d = s1_y_q;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            shadow_q   <= CFG_DEF;
            active_q   <= CFG_DEF;
            s1_vld_q   <= 1'b0;
            s1_match_q <= 1'b0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_match_q <= 1'b0;
            s2_r_q     <= '0;
            s2_g_q     <= '0;
            s2_b_q     <= '0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            s1_vld_q   <= s1_vld_d;
            s1_match_q <= s1_match_d;
            s1_r_q     <= s1_r_d;
            s1_g_q     <= s1_g_d;
            s1_b_q     <= s1_b_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_vld_q   <= s2_vld_d;
            s2_match_q <= s2_match_d;
            s2_r_q     <= s2_r_d;
            s2_g_q     <= s2_g_d;
            s2_b_q     <= s2_b_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
        end
    end

    // A match is counted on the edge it is loaded into S2.
    assign s2_inc = s1_vld_q && s1_match_q;

    frame_stat_accum #(
        .CNT_W   (CNT_W)
`ifdef COLOR_FILTER_CENTROID_EN
        ,
        .COORD_W (COORD_W)
`endif
    ) u_stat (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSOF       (iSOF),
        .iINC       (s2_inc),
`ifdef COLOR_FILTER_CENTROID_EN
        .iX         (s1_x_q),
        .iY         (s1_y_q),
        .oSUM_X     (oSUM_X),
        .oSUM_Y     (oSUM_Y),
`endif
        .oCOUNT     (oCOUNT),
        .oCOUNT_VLD (oCOUNT_VLD)
    );

    assign oRed   = s2_r_q;
    assign oGreen = s2_g_q;
    assign oBlue  = s2_b_q;
    assign oDVAL  = s2_vld_q;
    assign oX     = s2_x_q;
    assign oY     = s2_y_q;
    assign oMATCH = s2_match_q;

endmodule

// File: tb/tb_color_filter_param.sv
// Self-checking bench for color_filter_param against a frame-level reference model.
// Build with +define+COLOR_FILTER_CENTROID_EN to also check the coordinate sums.
module tb_color_filter_param;

    localparam int unsigned PIX_W    = 12;
    localparam int unsigned COORD_W  = 11;
    localparam int unsigned CNT_W    = 20;
    localparam int unsigned CNT_W_S  = 4;
    localparam int unsigned SUM_W    = COORD_W + CNT_W;
    localparam int unsigned SUM_W_S  = COORD_W + CNT_W_S;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [COORD_W-1:0] x, y;
    logic [PIX_W-1:0]   r, g, b;
    logic               dval, sof, we;
    logic [1:0]         addr;
    logic [PIX_W-1:0]   data;

    logic [PIX_W-1:0]   o_r, o_g, o_b;
    logic               o_dval, o_match, o_cvld, s_cvld;
    logic [COORD_W-1:0] o_x, o_y, s_x, s_y;
    logic [CNT_W-1:0]   o_cnt;
    logic [CNT_W_S-1:0] s_cnt;
    logic [PIX_W-1:0]   s_r, s_g, s_b;
    logic               s_dval, s_match;
`ifdef COLOR_FILTER_CENTROID_EN
    logic [SUM_W-1:0]   o_sx, o_sy;
    logic [SUM_W_S-1:0] s_sx, s_sy;
`endif

    color_filter_param #(.PIX_W(PIX_W), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
        .iCLK(clk), .iRST(rst), .iX_Cont(x), .iY_Cont(y),
        .iRed(r), .iGreen(g), .iBlue(b), .iDVAL(dval), .iSOF(sof),
        .iCFG_WE(we), .iCFG_ADDR(addr), .iCFG_DATA(data),
        .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oDVAL(o_dval),
        .oX(o_x), .oY(o_y), .oMATCH(o_match), .oCOUNT(o_cnt),
`ifdef COLOR_FILTER_CENTROID_EN
        .oSUM_X(o_sx), .oSUM_Y(o_sy),
`endif
        .oCOUNT_VLD(o_cvld)
    );

    color_filter_param #(.PIX_W(PIX_W), .COORD_W(COORD_W), .CNT_W(CNT_W_S)) dut_small (
        .iCLK(clk), .iRST(rst), .iX_Cont(x), .iY_Cont(y),
        .iRed(r), .iGreen(g), .iBlue(b), .iDVAL(dval), .iSOF(sof),
        .iCFG_WE(we), .iCFG_ADDR(addr), .iCFG_DATA(data),
        .oRed(s_r), .oGreen(s_g), .oBlue(s_b), .oDVAL(s_dval),
        .oX(s_x), .oY(s_y), .oMATCH(s_match), .oCOUNT(s_cnt),
`ifdef COLOR_FILTER_CENTROID_EN
        .oSUM_X(s_sx), .oSUM_Y(s_sy),
`endif
        .oCOUNT_VLD(s_cvld)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int     sh_pri, sh_oth, sh_chan, ac_pri, ac_oth, ac_chan;
    int     p1_v, p1_m, p1_r, p1_g, p1_b, p1_x, p1_y;
    int     e_v, e_m, e_r, e_g, e_b, e_x, e_y, e_cvld;
    longint cnt, cnt_s, e_cnt, e_cnt_s;
    longint sx, sy, sx_s, sy_s, e_sx, e_sy, e_sx_s, e_sy_s;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int f_match(input int rr, gg, bb, chan, pri, oth);
        int sel, a1, a2;
        if (chan == 3) return 1;
        if (chan == 0)      begin sel = rr; a1 = gg; a2 = bb; end
        else if (chan == 1) begin sel = gg; a1 = rr; a2 = bb; end
        else                begin sel = bb; a1 = rr; a2 = gg; end
        return (sel > pri && a1 < oth && a2 < oth) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input longint exp);
        total++;
        assert (obs === 64'(exp)) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int inc, pri, oth, chan;
        if (rst) begin
            sh_pri = 'h7FF; sh_oth = 'h3FF; sh_chan = 0;
            ac_pri = 'h7FF; ac_oth = 'h3FF; ac_chan = 0;
            p1_v = 0; p1_m = 0; p1_r = 0; p1_g = 0; p1_b = 0; p1_x = 0; p1_y = 0;
            e_v = 0; e_m = 0; e_r = 0; e_g = 0; e_b = 0; e_x = 0; e_y = 0; e_cvld = 0;
            cnt = 0; cnt_s = 0; e_cnt = 0; e_cnt_s = 0;
            sx = 0; sy = 0; sx_s = 0; sy_s = 0; e_sx = 0; e_sy = 0; e_sx_s = 0; e_sy_s = 0;
        end else begin
            inc = (p1_v != 0 && p1_m != 0) ? 1 : 0;
            e_v = p1_v;
            e_m = inc;
            if (p1_v != 0) begin
                e_r = (p1_m != 0) ? p1_r : 0;
                e_g = (p1_m != 0) ? p1_g : 0;
                e_b = (p1_m != 0) ? p1_b : 0;
                e_x = p1_x;
                e_y = p1_y;
            end
            if (sof) begin
                e_cvld  = 1;
                e_cnt   = sat(cnt + inc, CNT_W);
                e_cnt_s = sat(cnt_s + inc, CNT_W_S);
                e_sx    = sat(sx + inc * p1_x, SUM_W);
                e_sy    = sat(sy + inc * p1_y, SUM_W);
                e_sx_s  = sat(sx_s + inc * p1_x, SUM_W_S);
                e_sy_s  = sat(sy_s + inc * p1_y, SUM_W_S);
                cnt = inc; cnt_s = inc;
                sx = inc * p1_x; sy = inc * p1_y; sx_s = sx; sy_s = sy;
            end else begin
                e_cvld = 0;
                cnt    = sat(cnt + inc, CNT_W);
                cnt_s  = sat(cnt_s + inc, CNT_W_S);
                sx     = sat(sx + inc * p1_x, SUM_W);
                sy     = sat(sy + inc * p1_y, SUM_W);
                sx_s   = sat(sx_s + inc * p1_x, SUM_W_S);
                sy_s   = sat(sy_s + inc * p1_y, SUM_W_S);
            end
            pri  = sof ? sh_pri  : ac_pri;
            oth  = sof ? sh_oth  : ac_oth;
            chan = sof ? sh_chan : ac_chan;
            p1_v = dval ? 1 : 0;
            p1_m = dval ? f_match(int'(r), int'(g), int'(b), chan, pri, oth) : 0;
            if (dval) begin
                p1_r = int'(r); p1_g = int'(g); p1_b = int'(b);
                p1_x = int'(x); p1_y = int'(y);
            end
            if (sof) begin
                ac_pri = sh_pri; ac_oth = sh_oth; ac_chan = sh_chan;
            end
            if (we) begin
                case (addr)
                    2'd0: sh_pri  = int'(data);
                    2'd1: sh_oth  = int'(data);
                    2'd2: sh_chan = int'(data) % 4;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all();
        chk("oDVAL", o_dval, e_v);
        chk("oMATCH", o_match, e_m);
        chk("oRed", o_r, e_r);
        chk("oGreen", o_g, e_g);
        chk("oBlue", o_b, e_b);
        chk("oX", o_x, e_x);
        chk("oY", o_y, e_y);
        chk("oCOUNT", o_cnt, e_cnt);
        chk("oCOUNT_VLD", o_cvld, e_cvld);
        chk("small_oCOUNT", s_cnt, e_cnt_s);
        chk("small_oCOUNT_VLD", s_cvld, e_cvld);
        chk("small_oRed", s_r, e_r);
`ifdef COLOR_FILTER_CENTROID_EN
        chk("oSUM_X", o_sx, e_sx);
        chk("oSUM_Y", o_sy, e_sy);
        chk("small_oSUM_X", s_sx, e_sx_s);
        chk("small_oSUM_Y", s_sy, e_sy_s);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        dval = 1'b0; sof = 1'b0; we = 1'b0;
    endtask

    task automatic set_pix(input int rr, gg, bb, xx, yy);
        dval = 1'b1;
        r = PIX_W'(rr); g = PIX_W'(gg); b = PIX_W'(bb);
        x = COORD_W'(xx); y = COORD_W'(yy);
    endtask

    task automatic cfg_write(input int a, input int d);
        we = 1'b1; addr = 2'(a); data = PIX_W'(d);
        tick();
        we = 1'b0;
    endtask

    // Matching or non-matching pixel for red channel with thresholds 0x7FF / 0x3FF.
    task automatic set_red_pix(input bit want, input int xx, input int yy);
        int rr, gg, bb;
        if (want) begin
            rr = int'($urandom_range(12'h800, 12'hFFF));
            gg = int'($urandom_range(0, 12'h3FE));
            bb = int'($urandom_range(0, 12'h3FE));
        end else begin
            rr = int'($urandom_range(0, 12'hFFF));
            gg = int'($urandom_range(0, 12'hFFF));
            bb = int'($urandom_range(0, 12'hFFF));
            if (f_match(rr, gg, bb, 0, 'h7FF, 'h3FF) != 0) rr = rr & 'h7FF;
        end
        set_pix(rr, gg, bb, xx, yy);
    endtask

    initial begin
        int need;
        rst = 1'b1; x = '0; y = '0; r = '0; g = '0; b = '0;
        dval = 1'b0; sof = 1'b0; we = 1'b0; addr = '0; data = '0;
        tick();
        tick();
        chk("reset_oDVAL", o_dval, 0);
        chk("reset_oCOUNT", o_cnt, 0);
        rst = 1'b0;

        // First SOF after reset publishes zero.
        sof = 1'b1; tick(); sof = 1'b0;
        chk("first_sof_vld", o_cvld, 1);
        chk("first_sof_cnt", o_cnt, 0);

        // Default thresholds: pass, then reject at the threshold itself.
        set_pix('h800, 'h3FE, 'h000, 5, 7); tick();
        idle(); tick();
        chk("dflt_pass_red", o_r, 'h800);
        chk("dflt_pass_grn", o_g, 'h3FE);
        chk("dflt_pass_match", o_match, 1);
        chk("dflt_pass_x", o_x, 5);
        set_pix('h7FF, 'h3FE, 'h000, 6, 7); tick();
        idle(); tick();
        chk("at_pri_th_red", o_r, 0);
        chk("at_pri_th_match", o_match, 0);
        chk("at_pri_th_dval", o_dval, 1);
        tick();
        chk("bubble_dval", o_dval, 0);

        // Channel select written mid-frame only takes effect at the next SOF.
        cfg_write(2, 1);
        set_pix(0, 'hFFF, 0, 1, 1); tick();
        idle(); tick();
        chk("chan_pending_grn", o_g, 0);
        chk("chan_pending_match", o_match, 0);
        set_pix(0, 'hFFF, 0, 2, 1); sof = 1'b1; tick();
        idle(); tick();
        chk("chan_applied_grn", o_g, 'hFFF);
        chk("chan_applied_match", o_match, 1);

        // Bypass: every valid pixel passes unmodified.
        cfg_write(2, 3);
        sof = 1'b1; tick(); sof = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_pix(int'($urandom_range(0, 12'hFFF)), int'($urandom_range(0, 12'hFFF)),
                    int'($urandom_range(0, 12'hFFF)), i, 9);
            tick();
        end
        set_pix('h123, 'h456, 'h789, 30, 9); tick();
        idle(); tick();
        chk("bypass_red", o_r, 'h123);
        chk("bypass_blu", o_b, 'h789);
        chk("bypass_match", o_match, 1);

        // 100-pixel frame with exactly 37 matches, random bubbles.
        cfg_write(0, 'h7FF);
        cfg_write(1, 'h3FF);
        cfg_write(2, 0);
        sof = 1'b1; tick(); sof = 1'b0;
        need = 37;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) begin idle(); tick(); end
            if (int'($urandom_range(0, 99 - i)) < need) begin
                set_red_pix(1'b1, i, 4);
                need--;
            end else begin
                set_red_pix(1'b0, i, 4);
            end
            tick();
        end
        idle(); tick(); tick();
        // Close the frame while writing PRI_TH: this frame keeps using 0x7FF.
        sof = 1'b1; we = 1'b1; addr = 2'd0; data = 12'hFFF; tick();
        idle();
        chk("count37_cnt", o_cnt, 37);
        chk("count37_vld", o_cvld, 1);
        chk("count37_small_sat", s_cnt, 15);
        set_pix('h800, 0, 0, 0, 5); tick();
        chk("count37_vld_pulse", o_cvld, 0);
        idle(); tick();
        chk("sof_write_old_red", o_r, 'h800);

        // 20 matches in total: small counter saturates at 15.
        for (int i = 1; i < 20; i++) begin
            set_red_pix(1'b1, i, 5); tick();
            set_red_pix(1'b0, i, 5); tick();
        end
        idle(); tick(); tick();
        sof = 1'b1; we = 1'b1; addr = 2'd0; data = 12'h7FF; tick();
        idle();
        chk("count20_cnt", o_cnt, 20);
        chk("count20_small_sat", s_cnt, 15);

        // Random frames with random config writes, including reserved address.
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 40; i++) begin
                dval = ($urandom_range(0, 3) != 0);
                r = PIX_W'($urandom); g = PIX_W'($urandom); b = PIX_W'($urandom);
                x = COORD_W'(i); y = COORD_W'(f);
                we = ($urandom_range(0, 7) == 0);
                addr = 2'($urandom); data = PIX_W'($urandom);
                tick();
            end
            idle(); tick(); tick();
            sof = 1'b1; we = 1'($urandom); addr = 2'($urandom); data = PIX_W'($urandom);
            tick();
            idle();
        end

        // Reset mid-frame discards the partial count.
        cfg_write(2, 3);
        sof = 1'b1; tick(); sof = 1'b0;
        for (int i = 0; i < 3; i++) begin set_pix('h100, 'h200, 'h300, i, 0); tick(); end
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_dval", o_dval, 0);
        chk("rst_mid_vld", o_cvld, 0);
        sof = 1'b1; tick(); sof = 1'b0;
        chk("rst_mid_cnt", o_cnt, 0);
        chk("rst_mid_cnt_vld", o_cvld, 1);

        // Three matches at X=10,20,30 with default config.
        set_pix('h800, 0, 0, 10, 1); tick();
        set_pix('h800, 0, 0, 20, 2); tick();
        set_pix('h800, 0, 0, 30, 3); tick();
        idle(); tick(); tick();
        sof = 1'b1; tick(); sof = 1'b0;
        chk("centroid_cnt", o_cnt, 3);
`ifdef COLOR_FILTER_CENTROID_EN
        chk("centroid_sum_x", o_sx, 60);
        chk("centroid_sum_y", o_sy, 6);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
